// File: rtl/fx_host_master.sv
// fx bus initiator: turns host command bytes into fx_wr/fx_rd cycles and returns read data / write acks.
// Build option: define FX_BURST_EN to enable the 0x42 burst-read command (LEN/BNEXT states).
module fx_host_master #(
  parameter int RD_LAT = 2,
  parameter int TO_CYC = 50000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic        rx_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic [21:0] fx_waddr,
  output logic        fx_wr,
  output logic [7:0]  fx_data,
  output logic [21:0] fx_raddr,
  output logic        fx_rd,
  input  logic [7:0]  fx_q,
  output logic        busy,
  output logic        err_pls
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ADR2  = 4'd1;
  localparam logic [3:0] S_ADR1  = 4'd2;
  localparam logic [3:0] S_ADR0  = 4'd3;
  localparam logic [3:0] S_DAT   = 4'd4;
  localparam logic [3:0] S_WR    = 4'd5;
  localparam logic [3:0] S_RD    = 4'd6;
  localparam logic [3:0] S_RWAIT = 4'd7;
  localparam logic [3:0] S_TX    = 4'd8;
`ifdef FX_BURST_EN
  localparam logic [3:0] S_LEN   = 4'd9;
  localparam logic [3:0] S_BNEXT = 4'd10;
`endif

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] CMD_BR = 8'h42;
  localparam logic [7:0] ACK    = 8'h4B;

  localparam logic [1:0] M_WR = 2'd0;
  localparam logic [1:0] M_RD = 2'd1;
  localparam logic [1:0] M_BR = 2'd2;

  localparam logic [15:0] TO_M1  = 16'(TO_CYC - 1);
  localparam logic [2:0]  LAT_M1 = 3'(RD_LAT - 1);

  logic [3:0]  state, state_nxt;
  logic [1:0]  mode;
  logic [21:0] addr;
  logic [15:0] to_cnt;
  logic [2:0]  lat_cnt;
  logic        acc, waiting, timeout, lat_done, cmd_ok, rdy_nxt;
`ifdef FX_BURST_EN
  logic [8:0]  remain;
  logic        last_beat;
`endif

  always_comb begin
    acc      = rx_vld && rx_rdy;
    lat_done = (state == S_RWAIT) && (lat_cnt == LAT_M1);
`ifdef FX_BURST_EN
    waiting   = state inside {S_ADR2, S_ADR1, S_ADR0, S_DAT, S_LEN};
    cmd_ok    = (rx_data == CMD_WR) || (rx_data == CMD_RD) || (rx_data == CMD_BR);
    last_beat = (mode != M_BR) || (remain == 9'd1);
`else
    waiting   = state inside {S_ADR2, S_ADR1, S_ADR0, S_DAT};
    cmd_ok    = (rx_data == CMD_WR) || (rx_data == CMD_RD);
`endif
    timeout  = waiting && !acc && (to_cnt == TO_M1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (acc && cmd_ok) state_nxt = S_ADR2;
      S_ADR2:  if (timeout) state_nxt = S_IDLE; else if (acc) state_nxt = S_ADR1;
      S_ADR1:  if (timeout) state_nxt = S_IDLE; else if (acc) state_nxt = S_ADR0;
      S_ADR0: begin
        if (timeout) state_nxt = S_IDLE;
        else if (acc) begin
          case (mode)
            M_WR:    state_nxt = S_DAT;
`ifdef FX_BURST_EN
            M_BR:    state_nxt = S_LEN;
`endif
            default: state_nxt = S_RD;
          endcase
        end
      end
      S_DAT:   if (timeout) state_nxt = S_IDLE; else if (acc) state_nxt = S_WR;
      S_WR:    state_nxt = S_TX;
      S_RD:    state_nxt = S_RWAIT;
      S_RWAIT: if (lat_done) state_nxt = S_TX;
      S_TX: begin
        if (tx_vld && tx_rdy) begin
`ifdef FX_BURST_EN
          state_nxt = last_beat ? S_IDLE : S_BNEXT;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
`ifdef FX_BURST_EN
      S_LEN:   if (timeout) state_nxt = S_IDLE; else if (acc) state_nxt = S_RD;
      S_BNEXT: state_nxt = S_RD;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
`ifdef FX_BURST_EN
    rdy_nxt = state_nxt inside {S_IDLE, S_ADR2, S_ADR1, S_ADR0, S_DAT, S_LEN};
`else
    rdy_nxt = state_nxt inside {S_IDLE, S_ADR2, S_ADR1, S_ADR0, S_DAT};
`endif
  end

  // Strobes, busy and rx_rdy are registered from state_nxt so they line up with the state they describe.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      mode     <= M_WR;
      addr     <= '0;
      to_cnt   <= '0;
      lat_cnt  <= '0;
      rx_rdy   <= 1'b0;
      tx_data  <= '0;
      tx_vld   <= 1'b0;
      fx_waddr <= '0;
      fx_wr    <= 1'b0;
      fx_data  <= '0;
      fx_raddr <= '0;
      fx_rd    <= 1'b0;
      busy     <= 1'b0;
      err_pls  <= 1'b0;
`ifdef FX_BURST_EN
      remain   <= '0;
`endif
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt != S_IDLE);
      rx_rdy  <= rdy_nxt;
      fx_wr   <= (state_nxt == S_WR);
      fx_rd   <= (state_nxt == S_RD);
      err_pls <= timeout || ((state == S_IDLE) && acc && !cmd_ok);

      if (acc || !waiting || timeout) to_cnt <= '0;
      else                            to_cnt <= to_cnt + 16'd1;

      case (state)
        S_IDLE: begin
          if (acc) begin
            if (rx_data == CMD_WR)      mode <= M_WR;
            else if (rx_data == CMD_BR) mode <= M_BR;
            else                        mode <= M_RD;
          end
        end
        S_ADR2: if (acc) addr[21:16] <= rx_data[5:0];
        S_ADR1: if (acc) addr[15:8]  <= rx_data;
        S_ADR0: begin
          if (acc) begin
            addr[7:0] <= rx_data;
            if (mode == M_RD) fx_raddr <= {addr[21:8], rx_data};
          end
        end
        S_DAT: begin
          if (acc) begin
            fx_waddr <= addr;
            fx_data  <= rx_data;
          end
        end
        S_WR: begin
          tx_data <= ACK;
          tx_vld  <= 1'b1;
        end
        S_RD:   lat_cnt <= '0;
        S_RWAIT: begin
          lat_cnt <= lat_cnt + 3'd1;
          if (lat_done) begin
            tx_data <= fx_q;
            tx_vld  <= 1'b1;
          end
        end
        S_TX: begin
          if (tx_rdy) begin
            tx_vld <= 1'b0;
`ifdef FX_BURST_EN
            remain <= remain - 9'd1;
`endif
          end
        end
`ifdef FX_BURST_EN
        S_LEN: begin
          if (acc) begin
            fx_raddr <= addr;
            remain   <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          end
        end
        S_BNEXT: begin
          addr     <= addr + 22'd1;
          fx_raddr <= addr + 22'd1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fx_host_master.md
Name: fx_host_master

Overview:
- Initiator end of the fx register bus, the counterpart to the per-block register decoders that respond to it.
- Parses a host command byte stream (rx valid/ready) into fx_wr / fx_rd transactions and returns read data and write acks on a tx byte stream.
- Sits between the host byte link and the fx bus that fans out to all block register files.

Parameters:
RD_LAT, 2, cycles from fx_rd high to fx_q valid (1..7)
TO_CYC, 50000, idle cycles inside a partial packet before abort (16-bit)

Ports:
clk_sys  in  1  system clock
rst  in  1  asynchronous reset, active-high
rx_data  in  8  host command byte
rx_vld  in  1  rx_data valid
rx_rdy  out  1  master accepts byte (transfer = rx_vld & rx_rdy)
tx_data  out  8  response byte
tx_vld  out  1  response valid, held until accepted
tx_rdy  in  1  host accepts response
fx_waddr  out  22  write address
fx_wr  out  1  write strobe, one cycle
fx_data  out  8  write data
fx_raddr  out  22  read address
fx_rd  out  1  read strobe, one cycle
fx_q  in  8  read data from the bus
busy  out  1  high whenever state != IDLE
err_pls  out  1  one-cycle pulse on bad command byte or timeout

Behaviour:
- Reset (async, rst=1): state IDLE; rx_rdy=0 during reset, 1 in the first cycle after release. tx_vld, fx_wr, fx_rd, busy, err_pls = 0. tx_data, fx_waddr, fx_data, fx_raddr = 0. Asserting rst mid-packet discards the packet; no strobe issues afterwards.
- Packet format, bytes MSB first: CMD, A2, A1, A0, [D]. Address = {A2[5:0], A1, A0}; A2[7:6] ignored.
- CMD 0x57: write; D follows. CMD 0x52: read; no D.
- States: IDLE -> ADR2 -> ADR1 -> ADR0 -> (write: DAT -> WR) / (read: RD -> RWAIT) -> TX -> IDLE.
- rx_rdy=1 only in IDLE, ADR2, ADR1, ADR0, DAT; otherwise 0.
- Any other CMD value in IDLE: byte consumed, err_pls pulses next cycle, state stays IDLE.
- WR state (one cycle, entered the cycle after D accepted):
  - fx_wr=1; fx_waddr/fx_data driven the same cycle.
  - fx_waddr/fx_data hold their value until the next write.
  - Next state TX with tx_data=0x4B ('K').
- RD state (one cycle): fx_rd=1 and fx_raddr driven, held until the next read.
- RWAIT: counter samples fx_q exactly RD_LAT cycles after the fx_rd cycle into tx_data, then TX.
- TX: tx_vld=1 with tx_data stable until the tx_vld & tx_rdy cycle; tx_vld drops the next cycle and state returns to IDLE.
  - Read turnaround, last address byte accepted at cycle n: fx_rd at n+1; tx_vld first at n+2+RD_LAT.
- fx_wr and fx_rd are never high in the same cycle; at most one outstanding transaction.
- Timeout: 16-bit counter cleared on each accepted byte, counts in ADR2/ADR1/ADR0/DAT. When it reaches TO_CYC: return to IDLE, pulse err_pls, issue no strobe. No timeout in TX (host back-pressure may be unbounded).
- busy = (state != IDLE), registered.

Optional Feature:
- Macro FX_BURST_EN.
- Defined:
  - CMD 0x42 = burst read: CMD, A2, A1, A0, N. Count = N, with N=0 meaning 256.
  - Performs Count reads at addr, addr+1, ... Address wraps modulo 2^22 (0x3FFFFF -> 0x000000).
  - Each byte is returned in order via TX before the next fx_rd issues.
  - Uses extra states LEN and BNEXT; a 9-bit remaining counter ends the burst.
- Undefined: 0x42 is treated as an unknown command (err_pls, no bus activity); LEN/BNEXT logic is absent.

Test Plan:
- Write 57 01 23 45 AA, tx_rdy=1 -> one fx_wr pulse with fx_waddr=0x012345, fx_data=0xAA; tx byte 0x4B; busy back to 0.
- Read 52 C0 00 10, RD_LAT=2, fx_q=0x5A at the sample cycle -> fx_raddr=0x000010 (A2[7:6] ignored); fx_rd pulse; tx_data=0x5A appears exactly 4 cycles after the last address byte.
- Back-pressure: read with tx_rdy held 0 for 20 cycles -> tx_vld/tx_data stable for 20 cycles, rx_rdy=0 throughout; one byte delivered on release.
- Bad command 0x13, then a valid read -> err_pls one cycle, no strobe; following read completes normally.
- Send 57 00 00, then stall TO_CYC cycles -> err_pls, no fx_wr, IDLE; rst asserted mid-read -> no fx_rd, all outputs 0.
- With FX_BURST_EN: 42 3F FF FE 03 -> reads at 0x3FFFFE, 0x3FFFFF, 0x000000; three tx bytes in order. Without it: err_pls, no fx_rd.
